// File: rtl/divider_pkg.sv
// Shared types and constants for the divider sequencer and its operand FIFO.
//   DIV_W             : operand/result width of the attached divider
//   seq_state_t       : sequencer FSM states
//   DIV_ZERO_QUOTIENT : quotient reported for a trapped divide-by-zero
//   div_pair_t        : one buffered operand pair
package divider_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    OUTPUT  = 2'd3
  } seq_state_t;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUOTIENT = 8'hFF;

  typedef struct packed {
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
  } div_pair_t;

endpackage

// File: rtl/divider_sequencer_if.sv
// Bundle of all non-clock/reset signals of divider_sequencer.
//   in_*   : operand pair input stream (valid/ready)
//   div_*  : four-phase Req/Done link to the divider
//   out_*  : result output stream (valid/ready) with trap flags
//   busy   : sequencer activity indicator
// slave  = sequencer view, master = environment (feeder/divider/consumer) view.
interface divider_sequencer_if;
  import divider_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] in_dividend;
  logic [DIV_W-1:0] in_divisor;

  logic             div_req;
  logic [DIV_W-1:0] div_op1;
  logic [DIV_W-1:0] div_op2;
  logic             div_done;
  logic [DIV_W-1:0] div_quotient;
  logic [DIV_W-1:0] div_remainder;

  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] out_quotient;
  logic [DIV_W-1:0] out_remainder;
  logic             out_div_zero;
  logic             out_timeout;

  logic             busy;

  modport slave (
    input  in_valid, in_dividend, in_divisor,
    output in_ready,
    output div_req, div_op1, div_op2,
    input  div_done, div_quotient, div_remainder,
    output out_valid, out_quotient, out_remainder, out_div_zero, out_timeout,
    input  out_ready,
    output busy
  );

  modport master (
    output in_valid, in_dividend, in_divisor,
    input  in_ready,
    input  div_req, div_op1, div_op2,
    output div_done, div_quotient, div_remainder,
    input  out_valid, out_quotient, out_remainder, out_div_zero, out_timeout,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/divider_op_fifo.sv
// Operand-pair FIFO for the divider sequencer.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push, push_data : write one pair (ignored when full)
//   pop, pop_data   : pop_data shows the head entry; pop advances it (ignored when empty)
//   full, empty, count : occupancy status from registered count
module divider_op_fifo
  import divider_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  div_pair_t                  push_data,
  input  logic                       pop,
  output div_pair_t                  pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  div_pair_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // DEPTH is a power of two, so natural pointer overflow gives modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/divider_sequencer.sv
// Feeds buffered operand pairs to an 8-bit divider over a four-phase Req/Done
// handshake and returns quotient/remainder on a valid/ready stream.
//   Clock  : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : divider_sequencer_if.slave (input stream, divider link,
//            output stream, busy)
// Divide-by-zero is answered locally (Q=FF, R=dividend); a watchdog aborts a
// division whose Done never arrives within TIMEOUT cycles.
module divider_sequencer
  import divider_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                Clock,
  input  logic                nReset,
  divider_sequencer_if.slave  bus
);

  localparam int               CW        = $clog2(DEPTH+1);
  localparam logic [7:0]       TIMEOUT_W = 8'(TIMEOUT);

  div_pair_t         push_pair;
  div_pair_t         head_pair;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  seq_state_t        state_q,      state_d;
  logic [7:0]        wd_q,         wd_d;
  logic              div_req_q,    div_req_d;
  logic [DIV_W-1:0]  div_op1_q,    div_op1_d;
  logic [DIV_W-1:0]  div_op2_q,    div_op2_d;
  logic              out_valid_q,  out_valid_d;
  logic [DIV_W-1:0]  out_quot_q,   out_quot_d;
  logic [DIV_W-1:0]  out_rem_q,    out_rem_d;
  logic              out_dz_q,     out_dz_d;
  logic              out_to_q,     out_to_d;

  assign push_pair.dividend = bus.in_dividend;
  assign push_pair.divisor  = bus.in_divisor;
  assign fifo_push          = bus.in_valid && !fifo_full;

  divider_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (Clock),
    .rst_n     (nReset),
    .push      (fifo_push),
    .push_data (push_pair),
    .pop       (fifo_pop),
    .pop_data  (head_pair),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    div_req_d   = div_req_q;
    div_op1_d   = div_op1_q;
    div_op2_d   = div_op2_q;
    out_valid_d = out_valid_q;
    out_quot_d  = out_quot_q;
    out_rem_d   = out_rem_q;
    out_dz_d    = out_dz_q;
    out_to_d    = out_to_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_pair.divisor != '0) begin
            div_op1_d = head_pair.dividend;
            div_op2_d = head_pair.divisor;
            div_req_d = 1'b1;
            wd_d      = '0;
            state_d   = ISSUE;
          end else begin
            // Trapped locally: the divider never sees a zero divisor.
            out_quot_d  = DIV_ZERO_QUOTIENT;
            out_rem_d   = head_pair.dividend;
            out_dz_d    = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUTPUT;
          end
        end
      end
      ISSUE: begin
        wd_d = wd_q + 8'd1;
        // Done wins over the watchdog when both land in the same cycle.
        if (bus.div_done) begin
          out_quot_d = bus.div_quotient;
          out_rem_d  = bus.div_remainder;
          div_req_d  = 1'b0;
          state_d    = RELEASE;
        end else if (wd_q == TIMEOUT_W) begin
          out_quot_d = '0;
          out_rem_d  = '0;
          out_to_d   = 1'b1;
          div_req_d  = 1'b0;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        // Finish the four-phase handshake before the next Req can rise.
        if (!bus.div_done) begin
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_dz_d    = 1'b0;
          out_to_d    = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      div_req_q   <= 1'b0;
      div_op1_q   <= '0;
      div_op2_q   <= '0;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_dz_q    <= 1'b0;
      out_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      div_req_q   <= div_req_d;
      div_op1_q   <= div_op1_d;
      div_op2_q   <= div_op2_d;
      out_valid_q <= out_valid_d;
      out_quot_q  <= out_quot_d;
      out_rem_q   <= out_rem_d;
      out_dz_q    <= out_dz_d;
      out_to_q    <= out_to_d;
    end
  end

  assign bus.in_ready      = !fifo_full;
  assign bus.busy          = (state_q != IDLE) || (fifo_count != '0);
  assign bus.div_req       = div_req_q;
  assign bus.div_op1       = div_op1_q;
  assign bus.div_op2       = div_op2_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_quotient  = out_quot_q;
  assign bus.out_remainder = out_rem_q;
  assign bus.out_div_zero  = out_dz_q;
  assign bus.out_timeout   = out_to_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer with a behavioural divider model.
module tb_divider_sequencer;
  import divider_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       to;
  } exp_t;

  logic clk    = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  divider_sequencer_if bus();

  divider_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock  (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Divider model: Done after model_delay cycles of Req, held until Req drops.
  int   model_delay = 10;
  logic model_stuck = 1'b0;
  int   mcnt;
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bus.div_done      <= 1'b0;
      bus.div_quotient  <= '0;
      bus.div_remainder <= '0;
      mcnt              <= 0;
    end else if (model_stuck) begin
      bus.div_done <= 1'b0;
      mcnt         <= 0;
    end else if (bus.div_req && !bus.div_done) begin
      if (mcnt >= model_delay - 1) begin
        bus.div_done      <= 1'b1;
        bus.div_quotient  <= (bus.div_op2 != 0) ? bus.div_op1 / bus.div_op2 : 8'h00;
        bus.div_remainder <= (bus.div_op2 != 0) ? bus.div_op1 % bus.div_op2 : 8'h00;
        mcnt              <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end else if (!bus.div_req && bus.div_done) begin
      bus.div_done <= 1'b0;
    end
  end

  // Monitor: result scoreboard plus handshake protocol checks.
  logic       req_prev = 1'b0;
  logic [7:0] op1_prev = '0;
  logic [7:0] op2_prev = '0;
  always @(negedge clk) begin
    if (nReset) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got q=%0d r=%0d, expected no result",
                   bus.out_quotient, bus.out_remainder);
        end else begin
          check("result", 32'({bus.out_quotient, bus.out_remainder,
                               bus.out_div_zero, bus.out_timeout}), 32'(exp_q[0]));
          exp_q.delete(0);
        end
      end
      if (bus.div_req && !req_prev) check("req_rise_while_done", 32'(bus.div_done), 32'd0);
      if (bus.div_req && req_prev)
        check("ops_stable", 32'({bus.div_op1, bus.div_op2}), 32'({op1_prev, op2_prev}));
    end
    req_prev <= bus.div_req;
    op1_prev <= bus.div_op1;
    op2_prev <= bus.div_op2;
  end

  task automatic push(input logic [7:0] d, input logic [7:0] s,
                      input logic [7:0] eq, input logic [7:0] er,
                      input logic edz, input logic eto);
    bit ok = 0;
    exp_q.push_back('{q: eq, r: er, dz: edz, to: eto});
    bus.in_valid    = 1'b1;
    bus.in_dividend = d;
    bus.in_divisor  = s;
    for (int i = 0; i < 300; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_accept: pair %0d/%0d not accepted, required acceptance", d, s);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 500; i++) begin
      if (exp_q.size() == 0 && !bus.busy) break;
      @(posedge clk); #1;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int  cnt;
    bit  seen;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    #12;
    check("rst_div_req", 32'(bus.div_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data", 32'({bus.div_op1, bus.div_op2, bus.out_quotient, bus.out_remainder}), 32'd0);
    check("rst_flags", 32'({bus.out_div_zero, bus.out_timeout}), 32'd0);
    #10 nReset = 1'b1;
    @(posedge clk); #1;

    // Basic 9/3
    push(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("basic_req", 32'(bus.div_req), 32'd1);
    check("basic_ops", 32'({bus.div_op1, bus.div_op2}), 32'({8'd9, 8'd3}));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.div_done) begin seen = 1; break; end
      if (!bus.div_req) break;
      @(posedge clk); #1;
    end
    check("basic_done_seen", 32'(seen), 32'd1);
    check("basic_req_until_done", 32'(bus.div_req), 32'd1);
    wait_drain("basic");

    // Queue of three
    push(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0);
    push(8'd255, 8'd16, 8'd15, 8'd15, 1'b0, 1'b0);
    push(8'd8, 8'd9, 8'd0, 8'd8, 1'b0, 1'b0);
    wait_drain("queue");

    // Divide-by-zero
    push(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("dz_out_valid", 32'(bus.out_valid), 32'd1);
    check("dz_no_req", 32'(bus.div_req), 32'd0);
    wait_drain("dz");

    // Full and backpressure
    bus.out_ready = 1'b0;
    push(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 1'b0);
    push(8'd50, 8'd7, 8'd7, 8'd1, 1'b0, 1'b0);
    push(8'd13, 8'd5, 8'd2, 8'd3, 1'b0, 1'b0);
    push(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0);
    push(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("bp_out_valid", 32'(seen), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("bp_hold", 32'({bus.out_valid, bus.out_quotient, bus.out_remainder}),
          32'({1'b1, 8'd10, 8'd0}));
    check("bp_still_full", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    push(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, 1'b0);
    wait_drain("backpressure");

    // Watchdog timeout
    model_stuck = 1'b1;
    push(8'd10, 8'd2, 8'd0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (bus.div_req) break;
      @(posedge clk); #1;
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (!bus.div_req) break;
    end
    check("timeout_cycles", 32'(cnt), 32'd16);
    wait_drain("timeout");
    model_stuck = 1'b0;

    // Reset in ISSUE with two pairs queued
    push(8'd40, 8'd4, 8'd10, 8'd0, 1'b0, 1'b0);
    push(8'd41, 8'd4, 8'd10, 8'd1, 1'b0, 1'b0);
    push(8'd42, 8'd4, 8'd10, 8'd2, 1'b0, 1'b0);
    check("pre_reset_req", 32'(bus.div_req), 32'd1);
    #2 nReset = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.div_req), 32'd0);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    #3 nReset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.div_req || bus.out_valid) seen = 1;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
